// File: rtl/snoop_req_arbiter.sv
// Round-robin arbiter feeding three per-processor request FIFOs into a
// fixed-length snooping transaction window (one entry issued per window).
module snoop_req_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int WINDOW     = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [8:0]  req_tag,
  input  logic [5:0]  req_pos,
  input  logic [2:0]  req_op,
  input  logic [47:0] req_data,
  output logic [1:0]  proc_num,
  output logic [2:0]  m_tag,
  output logic [1:0]  tag_position,
  output logic        op,
  output logic [15:0] data,
  output logic        issue_valid,
  output logic [2:0]  step,
  output logic        done_pulse
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 + 2 + 1 + 16;
  localparam logic [2:0] LAST_STEP = 3'(WINDOW - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t state_reg, state_next;
  logic [2:0]  step_reg, step_next;
  logic [1:0]  last_grant_reg;
  logic        load;
  logic        grant_any;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic [2:0]  nonempty;
  logic [3:0]  nonempty_ext;
  logic [2:0]  push;
  logic [2:0]  pop;
  logic [ENTRY_W-1:0] head [0:3];

  logic [1:0]  proc_num_reg;
  logic [2:0]  m_tag_reg;
  logic [1:0]  pos_reg;
  logic        op_reg;
  logic [15:0] data_reg;

  // Per-processor queues; ready and non-empty come from registered count only.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_queue
      logic [ENTRY_W-1:0] mem_reg [FIFO_DEPTH];
      logic [PTR_W-1:0]   wr_ptr_reg;
      logic [PTR_W-1:0]   rd_ptr_reg;
      logic [CNT_W-1:0]   count_reg;

      assign req_ready[gi] = (count_reg < CNT_W'(FIFO_DEPTH));
      assign nonempty[gi]  = (count_reg != '0);
      assign push[gi]      = req_valid[gi] & req_ready[gi];
      assign head[gi]      = mem_reg[rd_ptr_reg];

      always_ff @(posedge clock) begin
        if (push[gi]) begin
          mem_reg[wr_ptr_reg] <= {req_tag[3*gi +: 3], req_pos[2*gi +: 2],
                                  req_op[gi], req_data[16*gi +: 16]};
        end
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (push[gi]) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop[gi])  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          case ({push[gi], pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end
    end
  endgenerate

  assign head[3]      = '0;
  assign nonempty_ext = {1'b0, nonempty};

  function automatic logic [1:0] next_idx(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // Round-robin search starting just after the previous grant.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    cand      = next_idx(last_grant_reg);
    for (int k = 0; k < 3; k++) begin
      if (!grant_any && nonempty_ext[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
      cand = next_idx(cand);
    end
  end

  always_comb begin
    state_next = state_reg;
    step_next  = step_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        step_next = 3'd0;
        if (grant_any) begin
          state_next = ISSUE;
          load       = 1'b1;
        end
      end
      ISSUE: begin
        if (step_reg == LAST_STEP) begin
          step_next = 3'd0;
          if (grant_any) begin
            load = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end else begin
          step_next = step_reg + 3'd1;
        end
      end
      default: begin
        state_next = IDLE;
        step_next  = 3'd0;
      end
    endcase
  end

  assign pop = load ? (3'b001 << grant_idx) : 3'b000;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= IDLE;
      step_reg       <= 3'd0;
      last_grant_reg <= 2'd2;
      proc_num_reg   <= 2'd0;
      m_tag_reg      <= 3'd0;
      pos_reg        <= 2'd0;
      op_reg         <= 1'b0;
      data_reg       <= 16'd0;
    end else begin
      state_reg <= state_next;
      step_reg  <= step_next;
      if (load) begin
        last_grant_reg <= grant_idx;
        proc_num_reg   <= grant_idx;
        {m_tag_reg, pos_reg, op_reg, data_reg} <= head[grant_idx];
      end
    end
  end

  assign issue_valid  = (state_reg == ISSUE);
  assign step         = step_reg;
  assign done_pulse   = issue_valid & (step_reg == LAST_STEP);
  assign proc_num     = proc_num_reg;
  assign m_tag        = m_tag_reg;
  assign tag_position = pos_reg;
  assign op           = op_reg;
  assign data         = data_reg;

endmodule

// File: tb/tb_snoop_req_arbiter.sv
// Scoreboard bench for snoop_req_arbiter: directed stimulus queues expected
// windows; a negedge monitor checks each window start and the window shape.
module tb_snoop_req_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_ready;
  logic [8:0]  req_tag = '0;
  logic [5:0]  req_pos = '0;
  logic [2:0]  req_op = '0;
  logic [47:0] req_data = '0;
  logic [1:0]  proc_num;
  logic [2:0]  m_tag;
  logic [1:0]  tag_position;
  logic        op;
  logic [15:0] data;
  logic        issue_valid;
  logic [2:0]  step;
  logic        done_pulse;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  logic rst_at_edge = 1'b1;

  typedef struct {
    int proc_i;
    int tag;
    int pos;
    int op_v;
    int data_v;
    int start;
  } exp_t;

  exp_t exp_q[$];

  snoop_req_arbiter #(.FIFO_DEPTH(2), .WINDOW(5)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_tag(req_tag), .req_pos(req_pos), .req_op(req_op), .req_data(req_data),
    .proc_num(proc_num), .m_tag(m_tag), .tag_position(tag_position),
    .op(op), .data(data), .issue_valid(issue_valid), .step(step),
    .done_pulse(done_pulse)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc <= cyc + 1;
    rst_at_edge <= reset;
  end

  task automatic check(input string name, input int act, input int expv);
    n_checks++;
    if (act !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, expv, expv, cyc);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clock);
  endtask

  task automatic set_port(input int i, input bit v, input int tag, input int pos,
                          input int o, input int d);
    req_valid[i]       = v;
    req_tag[3*i +: 3]  = 3'(tag);
    req_pos[2*i +: 2]  = 2'(pos);
    req_op[i]          = 1'(o);
    req_data[16*i +: 16] = 16'(d);
  endtask

  task automatic expect_win(input int p, input int tag, input int pos,
                            input int o, input int d, input int start);
    exp_t e;
    e.proc_i = p; e.tag = tag; e.pos = pos; e.op_v = o; e.data_v = d; e.start = start;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    exp_q.delete();
    tick(2);
    reset = 1'b0;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_step", step, 0);
    check("rst_done", done_pulse, 0);
    check("rst_proc_num", proc_num, 0);
    check("rst_m_tag", m_tag, 0);
    check("rst_pos", tag_position, 0);
    check("rst_op", op, 0);
    check("rst_data", data, 0);
    check("rst_ready", req_ready, 3'b111);
  endtask

  // Monitor: window starts are matched against the scoreboard; every other
  // cycle checks step sequencing, done_pulse and field stability.
  exp_t mon_e;
  bit   mon_prev_valid = 1'b0;
  int   mon_prev_step = 0;
  int   held_proc, held_tag, held_pos, held_op, held_data;

  always @(negedge clock) begin
    if (rst_at_edge) begin
      mon_prev_valid = 1'b0;
      mon_prev_step  = 0;
    end else begin
      if (issue_valid) begin
        check("done_pulse", done_pulse, (step == 3'd4) ? 1 : 0);
        if (step == 3'd0) begin
          if (mon_prev_valid) check("b2b_prev_step", mon_prev_step, 4);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_window: got proc %0d tag %0d, expected no window at cycle %0d",
                     proc_num, m_tag, cyc);
          end else begin
            mon_e = exp_q.pop_front();
            check("win_start_cycle", cyc, mon_e.start);
            check("win_proc_num", proc_num, mon_e.proc_i);
            check("win_m_tag", m_tag, mon_e.tag);
            check("win_pos", tag_position, mon_e.pos);
            check("win_op", op, mon_e.op_v);
            check("win_data", data, mon_e.data_v);
          end
          held_proc = proc_num; held_tag = m_tag; held_pos = tag_position;
          held_op = op; held_data = data;
        end else begin
          check("step_seq", step, mon_prev_valid ? mon_prev_step + 1 : -1);
          check("hold_fields", {proc_num, m_tag, tag_position, op, data},
                {held_proc[1:0], held_tag[2:0], held_pos[1:0], held_op[0], held_data[15:0]});
        end
      end else begin
        check("idle_step", step, 0);
        check("idle_done", done_pulse, 0);
        if (mon_prev_valid) check("window_end_step", mon_prev_step, 4);
      end
      mon_prev_valid = issue_valid;
      mon_prev_step  = step;
    end
  end

  int d;
  int ready_tbl [6] = '{1, 1, 0, 0, 0, 1};
  int entry_tbl [6] = '{0, 1, 2, 2, 2, 2};

  initial begin
    tick(3);

    // Single request from processor 1.
    do_reset();
    d = cyc;
    set_port(1, 1, 5, 2, 0, 16'h1234);
    expect_win(1, 5, 2, 0, 16'h1234, d + 2);
    tick(1);
    req_valid = '0;
    tick(5);
    check("t1_last_done", done_pulse, 1);
    tick(1);
    check("t1_idle_after", issue_valid, 0);
    check("t1_hold_proc", proc_num, 1);
    check("t1_hold_tag", m_tag, 5);
    check("t1_hold_data", data, 16'h1234);

    // All three processors at once: back-to-back windows 0,1,2.
    do_reset();
    d = cyc;
    set_port(0, 1, 1, 0, 1, 16'hA000);
    set_port(1, 1, 2, 1, 0, 16'hB111);
    set_port(2, 1, 3, 3, 1, 16'hC222);
    expect_win(0, 1, 0, 1, 16'hA000, d + 2);
    expect_win(1, 2, 1, 0, 16'hB111, d + 7);
    expect_win(2, 3, 3, 1, 16'hC222, d + 12);
    tick(1);
    req_valid = '0;
    tick(15);
    check("t2_last_proc", proc_num, 2);
    check("t2_last_done", done_pulse, 1);
    tick(1);
    check("t2_idle_after", issue_valid, 0);

    // Port 0 fills its queue while port 2 holds a window.
    do_reset();
    d = cyc;
    set_port(2, 1, 4, 1, 1, 16'h2222);
    expect_win(2, 4, 1, 1, 16'h2222, d + 2);
    expect_win(0, 1, 0, 0, 16'h0A00, d + 7);
    expect_win(0, 2, 1, 1, 16'h0A01, d + 12);
    expect_win(0, 3, 2, 0, 16'h0A02, d + 17);
    tick(1);
    req_valid = '0;
    tick(1);
    for (int j = 0; j < 6; j++) begin
      check("t3_ready0", req_ready[0], ready_tbl[j]);
      set_port(0, 1, entry_tbl[j] + 1, entry_tbl[j], entry_tbl[j] % 2,
               16'h0A00 + entry_tbl[j]);
      tick(1);
    end
    req_valid = '0;
    tick(14);
    check("t3_idle_after", issue_valid, 0);
    check("t3_ready_all", req_ready, 3'b111);

    // Ports 0 and 1 continuously valid, then reset in step 2 of window 6.
    do_reset();
    d = cyc;
    set_port(0, 1, 6, 1, 1, 16'h0A0A);
    set_port(1, 1, 7, 2, 0, 16'h1B1B);
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) expect_win(0, 6, 1, 1, 16'h0A0A, d + 2 + 5 * k);
      else            expect_win(1, 7, 2, 0, 16'h1B1B, d + 2 + 5 * k);
    end
    tick(29);
    check("t4_queued_ready", req_ready, 3'b100);
    check("t4_step2", step, 2);
    check("t4_proc", proc_num, 1);
    reset = 1'b1;
    req_valid = '0;
    tick(1);
    check("t4_abort_valid", issue_valid, 0);
    check("t4_abort_step", step, 0);
    check("t4_abort_done", done_pulse, 0);
    check("t4_abort_ready", req_ready, 3'b111);
    reset = 1'b0;
    tick(20);
    check("t4_no_replay", issue_valid, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
